// File: rtl/lcd_dma_axi_reader_if.sv
// AXI4 read-address / read-data channel bundle between the LCD DMA reader and its slave.
interface lcd_dma_axi_reader_if;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    output M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    input  M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );
endinterface

// File: rtl/lcd_dma_axi_reader.sv
// Fixed-length AXI4 INCR burst reader feeding lcd_dma_fifo; one burst per DMA_START,
// every returned beat forwarded as a registered one-cycle DMA_RD_DATA_VALID pulse.
module lcd_dma_axi_reader #(
  parameter int          BURST_SIZE  = 8,
  parameter logic [3:0]  AXI_ARCACHE = 4'b0011
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [29:0] DMA_RD_ADDR,
  input  logic        DMA_START,
  output logic        DMA_READY,
  output logic [31:0] DMA_RD_DATA,
  output logic        DMA_RD_DATA_VALID,
  output logic [2:0]  ERROR_STATUS,
  input  logic        ERROR_CLEAR,
  lcd_dma_axi_reader_if.master m_axi
);

  localparam logic [7:0]  LAST_BEAT = 8'(BURST_SIZE - 1);
  localparam logic [12:0] SPAN      = 13'(4 * BURST_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_nxt;
  logic [31:0] araddr;
  logic [7:0]  beat_cnt;
  logic        start_ok, ar_hs, r_hs, last_beat;
  logic [12:0] end_off;
  logic [2:0]  err_set;

  assign start_ok  = (state == IDLE) && DMA_START;
  assign ar_hs     = m_axi.M_AXI_ARVALID && m_axi.M_AXI_ARREADY;
  assign r_hs      = m_axi.M_AXI_RVALID && m_axi.M_AXI_RREADY;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // Bit 12 of the last byte offset within the 4KB page flags a page crossing.
  assign end_off = {1'b0, DMA_RD_ADDR[9:0], 2'b00} + SPAN;

  assign err_set[0] = r_hs && (m_axi.M_AXI_RRESP != 2'b00);
  assign err_set[1] = r_hs && (m_axi.M_AXI_RLAST != last_beat);
  assign err_set[2] = start_ok && end_off[12];

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (DMA_START) state_nxt = ADDR;
      ADDR:    if (ar_hs) state_nxt = DATA;
      DATA:    if (r_hs && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ARVALID/RREADY are pure state decodes, so never combinational on ARREADY.
  always_comb begin
    DMA_READY           = (state == IDLE);
    m_axi.M_AXI_ARVALID = (state == ADDR);
    m_axi.M_AXI_RREADY  = (state == DATA);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      araddr            <= '0;
      beat_cnt          <= '0;
      DMA_RD_DATA       <= '0;
      DMA_RD_DATA_VALID <= 1'b0;
      ERROR_STATUS      <= '0;
    end else begin
      DMA_RD_DATA_VALID <= r_hs;
      if (r_hs) begin
        DMA_RD_DATA <= m_axi.M_AXI_RDATA;
        beat_cnt    <= beat_cnt + 8'd1;
      end
      if (start_ok) begin
        araddr   <= {DMA_RD_ADDR, 2'b00};
        beat_cnt <= '0;
      end
      // A fresh error in the same cycle as ERROR_CLEAR survives the clear.
      ERROR_STATUS <= (ERROR_CLEAR ? 3'b000 : ERROR_STATUS) | err_set;
    end
  end

  assign m_axi.M_AXI_ARADDR  = araddr;
  assign m_axi.M_AXI_ARLEN   = LAST_BEAT;
  assign m_axi.M_AXI_ARSIZE  = 3'b010;
  assign m_axi.M_AXI_ARBURST = 2'b01;
  assign m_axi.M_AXI_ARCACHE = AXI_ARCACHE;
  assign m_axi.M_AXI_ARPROT  = 3'b000;

endmodule
